// File: rtl/chu_mfifo_core.sv
// Multi-channel MMIO FIFO slot: N_CH independent FIFOs fed by hardware push ports
// and the bus, popped by software, with per-channel threshold, sticky flags and irq.
module chu_mfifo_core #(
   parameter int N_CH       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cs,
   input  logic                       read,
   input  logic                       write,
   input  logic [4:0]                 addr,
   input  logic [31:0]                wr_data,
   output logic [31:0]                rd_data,
   input  logic [N_CH-1:0]            hw_wr,
   input  logic [N_CH*DATA_WIDTH-1:0] hw_din,
   output logic [N_CH-1:0]            empty,
   output logic [N_CH-1:0]            full,
   output logic                       irq
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;

   logic [2:0] ch_sel;
   logic [1:0] reg_sel;

   logic [ADDR_WIDTH-1:0] wr_ptr_q [N_CH];
   logic [ADDR_WIDTH-1:0] wr_ptr_d [N_CH];
   logic [ADDR_WIDTH-1:0] rd_ptr_q [N_CH];
   logic [ADDR_WIDTH-1:0] rd_ptr_d [N_CH];
   logic [CW-1:0]         count_q  [N_CH];
   logic [CW-1:0]         count_d  [N_CH];
   logic [CW-1:0]         thresh_q [N_CH];
   logic [CW-1:0]         thresh_d [N_CH];
   logic [2:0]            irq_en_q [N_CH];
   logic [2:0]            irq_en_d [N_CH];
   logic                  ovf_q    [N_CH];
   logic                  ovf_d    [N_CH];
   logic                  udf_q    [N_CH];
   logic                  udf_d    [N_CH];
   logic                  irq_q;
   logic                  irq_d;

   logic [DATA_WIDTH-1:0] mem_q [N_CH][DEPTH];

   logic                  bus_sel     [N_CH];
   logic                  bus_push    [N_CH];
   logic                  pop_req     [N_CH];
   logic                  flush_req   [N_CH];
   logic                  clr_req     [N_CH];
   logic                  push_req    [N_CH];
   logic                  do_push     [N_CH];
   logic                  do_pop      [N_CH];
   logic [DATA_WIDTH-1:0] push_data   [N_CH];
   logic                  almost_full [N_CH];

   // The read strobe has no side effects, and upper write-data bits are not stored.
   logic unused_bits;
   assign unused_bits = ^{read, wr_data};

   assign ch_sel  = addr[4:2];
   assign reg_sel = addr[1:0];
   assign irq     = irq_q;

   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         empty[c]       = (count_q[c] == '0);
         full[c]        = (count_q[c] == CW'(DEPTH));
         almost_full[c] = (count_q[c] >= thresh_q[c]);
      end
   end

   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      irq_d = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         wr_ptr_d[c] = wr_ptr_q[c];
         rd_ptr_d[c] = rd_ptr_q[c];
         count_d[c]  = count_q[c];
         thresh_d[c] = thresh_q[c];
         irq_en_d[c] = irq_en_q[c];
         ovf_d[c]    = ovf_q[c];
         udf_d[c]    = udf_q[c];

         bus_sel[c]   = cs && write && (ch_sel == 3'(c));
         bus_push[c]  = bus_sel[c] && (reg_sel == 2'd0);
         pop_req[c]   = bus_sel[c] && (reg_sel == 2'd1) && wr_data[0];
         flush_req[c] = bus_sel[c] && (reg_sel == 2'd1) && wr_data[1];
         clr_req[c]   = bus_sel[c] && (reg_sel == 2'd1) && wr_data[2];
         push_req[c]  = hw_wr[c] || bus_push[c];
         push_data[c] = hw_wr[c] ? hw_din[c*DATA_WIDTH +: DATA_WIDTH]
                                 : wr_data[DATA_WIDTH-1:0];

         // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
         do_pop[c]  = pop_req[c] && !empty[c] && !flush_req[c];
         do_push[c] = push_req[c] && !flush_req[c] && (!full[c] || do_pop[c]);

         if (clr_req[c]) begin
            ovf_d[c] = 1'b0;
            udf_d[c] = 1'b0;
         end

         if (flush_req[c]) begin
            wr_ptr_d[c] = '0;
            rd_ptr_d[c] = '0;
            count_d[c]  = '0;
         end else begin
            if (pop_req[c] && empty[c])
               udf_d[c] = 1'b1;
            if ((push_req[c] && !do_push[c]) || (hw_wr[c] && bus_push[c]))
               ovf_d[c] = 1'b1;
            if (do_push[c])
               wr_ptr_d[c] = wr_ptr_q[c] + ADDR_WIDTH'(1);
            if (do_pop[c])
               rd_ptr_d[c] = rd_ptr_q[c] + ADDR_WIDTH'(1);
            if (do_push[c] && !do_pop[c])
               count_d[c] = count_q[c] + CW'(1);
            else if (do_pop[c] && !do_push[c])
               count_d[c] = count_q[c] - CW'(1);
         end

         if (bus_sel[c] && (reg_sel == 2'd2))
            thresh_d[c] = wr_data[CW-1:0];
         if (bus_sel[c] && (reg_sel == 2'd3))
            irq_en_d[c] = wr_data[2:0];

         irq_d = irq_d | (|(irq_en_q[c] & {udf_q[c], ovf_q[c], almost_full[c]}));
      end
   end

   always_comb begin
      rd_data = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (ch_sel == 3'(c)) begin
            case (reg_sel)
               2'd0: if (!empty[c]) rd_data[DATA_WIDTH-1:0] = mem_q[c][rd_ptr_q[c]];
               2'd1: begin
                  rd_data[CW-1:0] = count_q[c];
                  rd_data[16]     = empty[c];
                  rd_data[17]     = full[c];
                  rd_data[18]     = almost_full[c];
                  rd_data[19]     = ovf_q[c];
                  rd_data[20]     = udf_q[c];
               end
               2'd2: rd_data[CW-1:0] = thresh_q[c];
               default: rd_data[2:0] = irq_en_q[c];
            endcase
         end
      end
   end

   // NOTE: storage has no reset; emptiness is tracked by count and pointers, so
   // stale words are never visible and the array maps onto distributed RAM.
   always_ff @(posedge clk) begin
      for (int c = 0; c < N_CH; c++)
         if (do_push[c]) mem_q[c][wr_ptr_q[c]] <= push_data[c];
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < N_CH; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            count_q[c]  <= '0;
            thresh_q[c] <= CW'(DEPTH);
            irq_en_q[c] <= '0;
            ovf_q[c]    <= 1'b0;
            udf_q[c]    <= 1'b0;
         end
         irq_q <= 1'b0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            wr_ptr_q[c] <= wr_ptr_d[c];
            rd_ptr_q[c] <= rd_ptr_d[c];
            count_q[c]  <= count_d[c];
            thresh_q[c] <= thresh_d[c];
            irq_en_q[c] <= irq_en_d[c];
            ovf_q[c]    <= ovf_d[c];
            udf_q[c]    <= udf_d[c];
         end
         irq_q <= irq_d;
      end
   end

endmodule

// File: tb/tb_chu_mfifo_core.sv
// Directed bench for chu_mfifo_core (N_CH=4, DATA_WIDTH=8, ADDR_WIDTH=4): register
// map, push/pop rules, overflow/underflow, threshold irq and asynchronous reset.
module tb_chu_mfifo_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs, read, write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [3:0]  hw_wr;
   logic [31:0] hw_din;
   logic [3:0]  empty, full;
   logic        irq;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [31:0] rdata;

   chu_mfifo_core #(.N_CH(4), .DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .hw_wr(hw_wr), .hw_din(hw_din),
      .empty(empty), .full(full), .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] ra(input int ch, input int rg);
      return 5'((ch << 2) | rg);
   endfunction

   // Each bus write spans exactly one rising edge, starting and ending on a falling edge.
   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
      @(negedge clk);
      cs = 1'b0; write = 1'b0; wr_data = '0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      cs = 1'b1; read = 1'b1; addr = a;
      #1 d = rd_data;
      cs = 1'b0; read = 1'b0;
   endtask

   task automatic hw_push(input int ch, input logic [7:0] v);
      hw_wr = '0; hw_wr[ch] = 1'b1; hw_din[ch*8 +: 8] = v;
      @(negedge clk);
      hw_wr = '0;
   endtask

   task automatic test_reset;
      reset = 1'b0; cs = 0; read = 0; write = 0; addr = '0; wr_data = '0;
      hw_wr = '0; hw_din = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bus_read(ra(0, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0001_0000) begin tests_failed++;
         $display("FAIL reset_status_ch0: got %h expected %h", rdata, 32'h0001_0000); end
      bus_read(ra(2, 2), rdata);
      tests_run++;
      if (rdata !== 32'd16) begin tests_failed++;
         $display("FAIL reset_thresh_ch2: got %h expected %h", rdata, 32'd16); end
      bus_read(ra(0, 0), rdata);
      tests_run++;
      if (rdata !== 32'h0) begin tests_failed++;
         $display("FAIL reset_data_ch0: got %h expected 0", rdata); end
      tests_run++;
      if (empty !== 4'b1111 || full !== 4'b0000) begin tests_failed++;
         $display("FAIL reset_empty_full: got %b/%b expected 1111/0000", empty, full); end
      tests_run++;
      if (irq !== 1'b0) begin tests_failed++;
         $display("FAIL reset_irq: got %b expected 0", irq); end
      bus_write(ra(5, 0), 32'hAB);
      bus_read(ra(5, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0 || empty !== 4'b1111) begin tests_failed++;
         $display("FAIL unmapped_channel: got %h/%b expected 0/1111", rdata, empty); end
   endtask

   task automatic test_hw_push;
      hw_push(1, 8'h11);
      hw_push(1, 8'h22);
      hw_push(1, 8'h33);
      bus_read(ra(1, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0000_0003) begin tests_failed++;
         $display("FAIL hw_push_count: got %h expected %h", rdata, 32'h3); end
      bus_read(ra(1, 0), rdata);
      tests_run++;
      if (rdata !== 32'h11) begin tests_failed++;
         $display("FAIL hw_push_head: got %h expected %h", rdata, 32'h11); end
      bus_write(ra(1, 1), 32'h1);
      bus_read(ra(1, 0), rdata);
      tests_run++;
      if (rdata !== 32'h22) begin tests_failed++;
         $display("FAIL pop_head: got %h expected %h", rdata, 32'h22); end
      tests_run++;
      if (empty !== 4'b1101) begin tests_failed++;
         $display("FAIL other_channels_empty: got %b expected 1101", empty); end
   endtask

   task automatic test_collision;
      hw_wr = 4'b0010; hw_din[15:8] = 8'h77;
      bus_write(ra(1, 0), 32'h99);
      hw_wr = '0;
      bus_read(ra(1, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0008_0003) begin tests_failed++;
         $display("FAIL collision_status: got %h expected %h", rdata, 32'h0008_0003); end
      bus_write(ra(1, 1), 32'h1);
      bus_write(ra(1, 1), 32'h1);
      bus_read(ra(1, 0), rdata);
      tests_run++;
      if (rdata !== 32'h77) begin tests_failed++;
         $display("FAIL collision_hw_word: got %h expected %h", rdata, 32'h77); end
   endtask

   task automatic test_flush_vs_hw;
      hw_wr = 4'b0010; hw_din[15:8] = 8'h55;
      bus_write(ra(1, 1), 32'h6);
      hw_wr = '0;
      bus_read(ra(1, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0001_0000) begin tests_failed++;
         $display("FAIL flush_beats_hw: got %h expected %h", rdata, 32'h0001_0000); end
   endtask

   task automatic test_fill_overflow;
      for (int i = 0; i < 16; i++) bus_write(ra(0, 0), 32'hA0 + 32'(i));
      bus_read(ra(0, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0006_0010 || full[0] !== 1'b1) begin tests_failed++;
         $display("FAIL fill_status: got %h full=%b expected %h full=1", rdata, full[0], 32'h0006_0010); end
      bus_write(ra(0, 0), 32'hEE);
      bus_read(ra(0, 1), rdata);
      tests_run++;
      if (rdata !== 32'h000E_0010) begin tests_failed++;
         $display("FAIL overflow_status: got %h expected %h", rdata, 32'h000E_0010); end
      bus_read(ra(0, 0), rdata);
      tests_run++;
      if (rdata !== 32'hA0) begin tests_failed++;
         $display("FAIL overflow_head: got %h expected %h", rdata, 32'hA0); end
      hw_wr = 4'b0001; hw_din[7:0] = 8'h5A;
      bus_write(ra(0, 1), 32'h1);
      hw_wr = '0;
      bus_read(ra(0, 1), rdata);
      tests_run++;
      if (rdata !== 32'h000E_0010) begin tests_failed++;
         $display("FAIL full_push_pop_count: got %h expected %h", rdata, 32'h000E_0010); end
      bus_read(ra(0, 0), rdata);
      tests_run++;
      if (rdata !== 32'hA1) begin tests_failed++;
         $display("FAIL full_push_pop_head: got %h expected %h", rdata, 32'hA1); end
      for (int i = 0; i < 15; i++) bus_write(ra(0, 1), 32'h1);
      bus_read(ra(0, 0), rdata);
      tests_run++;
      if (rdata !== 32'h5A) begin tests_failed++;
         $display("FAIL wrapped_word: got %h expected %h", rdata, 32'h5A); end
      bus_read(ra(0, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0008_0001) begin tests_failed++;
         $display("FAIL drained_status: got %h expected %h", rdata, 32'h0008_0001); end
      bus_write(ra(0, 1), 32'h6);
      bus_read(ra(0, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0001_0000) begin tests_failed++;
         $display("FAIL flush_clear_ch0: got %h expected %h", rdata, 32'h0001_0000); end
   endtask

   task automatic test_irq_almost_full;
      bus_write(ra(3, 2), 32'd4);
      bus_write(ra(3, 3), 32'h1);
      for (int i = 0; i < 4; i++) hw_push(3, 8'(8'h30 + i));
      tests_run++;
      if (irq !== 1'b0) begin tests_failed++;
         $display("FAIL irq_registered_delay: got %b expected 0", irq); end
      @(negedge clk);
      tests_run++;
      if (irq !== 1'b1) begin tests_failed++;
         $display("FAIL irq_almost_full: got %b expected 1", irq); end
      bus_read(ra(3, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0004_0004) begin tests_failed++;
         $display("FAIL almost_full_status: got %h expected %h", rdata, 32'h0004_0004); end
      bus_write(ra(3, 1), 32'h1);
      @(negedge clk);
      tests_run++;
      if (irq !== 1'b0) begin tests_failed++;
         $display("FAIL irq_after_pop: got %b expected 0", irq); end
      bus_write(ra(3, 3), 32'h0);
      bus_write(ra(3, 1), 32'h2);
   endtask

   task automatic test_underflow;
      bus_write(ra(2, 3), 32'h4);
      bus_write(ra(2, 1), 32'h1);
      bus_read(ra(2, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0011_0000) begin tests_failed++;
         $display("FAIL underflow_status: got %h expected %h", rdata, 32'h0011_0000); end
      @(negedge clk);
      tests_run++;
      if (irq !== 1'b1) begin tests_failed++;
         $display("FAIL irq_underflow: got %b expected 1", irq); end
      bus_write(ra(2, 1), 32'h4);
      bus_read(ra(2, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0001_0000) begin tests_failed++;
         $display("FAIL clear_flags: got %h expected %h", rdata, 32'h0001_0000); end
      @(negedge clk);
      tests_run++;
      if (irq !== 1'b0) begin tests_failed++;
         $display("FAIL irq_after_clear: got %b expected 0", irq); end
      bus_write(ra(2, 3), 32'h0);
   endtask

   task automatic test_reset_midfill;
      hw_push(0, 8'h01);
      hw_push(2, 8'h02);
      hw_wr = 4'b0101;
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if (empty !== 4'b1111 || full !== 4'b0000) begin tests_failed++;
         $display("FAIL async_reset_empty: got %b/%b expected 1111/0000", empty, full); end
      hw_wr = '0;
      bus_read(ra(0, 1), rdata);
      tests_run++;
      if (rdata !== 32'h0001_0000) begin tests_failed++;
         $display("FAIL async_reset_count: got %h expected %h", rdata, 32'h0001_0000); end
      bus_read(ra(2, 0), rdata);
      tests_run++;
      if (rdata !== 32'h0 || irq !== 1'b0) begin tests_failed++;
         $display("FAIL async_reset_data_irq: got %h/%b expected 0/0", rdata, irq); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_hw_push;
      test_collision;
      test_flush_vs_hw;
      test_fill_overflow;
      test_irq_almost_full;
      test_underflow;
      test_reset_midfill;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
